// File: rtl/microroc_sc_pkg.sv
// ---------------------------------------------------------------------------
// microroc_sc_pkg
// Shared definitions for the MICROROC slow-control loader:
//   - loader FSM state encoding
//   - default frame length, SR_CK divider and SC reset hold time
//   - DAC0 field width
// ---------------------------------------------------------------------------
package microroc_sc_pkg;

  localparam int SC_LEN_DEF     = 592;
  localparam int CLK_DIV_DEF    = 4;
  localparam int RST_CYCLES_DEF = 8;
  localparam int DAC_W          = 10;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RST    = 3'd1,
    ST_SHIFT  = 3'd2,
    ST_VERIFY = 3'd3,
    ST_DONE   = 3'd4
  } sc_state_e;

endpackage

// File: rtl/sc_bit_clock_gen.sv
// ---------------------------------------------------------------------------
// sc_bit_clock_gen
// Divides clk by CLK_DIV to produce the slow-control shift clock.
// Within each bit period SR_CK is low for the first CLK_DIV/2 clk cycles and
// high for the rest. The divider phase is held at 0 while disabled, so the
// first enabled cycle is always the start of a bit period.
// Ports:
//   i_clk          system clock
//   i_rst_n        asynchronous active-low reset
//   i_en           run the divider (SHIFT/VERIFY)
//   o_sck          registered shift clock
//   o_sck_fall     last cycle of a bit period; SR_CK falls at the next edge
//   o_sck_sample   cycle before the SR_CK rising edge
// ---------------------------------------------------------------------------
module sc_bit_clock_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_en,
  output logic o_sck,
  output logic o_sck_fall,
  output logic o_sck_sample
);

  localparam int PH_W = $clog2(CLK_DIV);
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(CLK_DIV - 1);
  localparam logic [PH_W-1:0] PH_HALF = PH_W'(CLK_DIV / 2);
  localparam logic [PH_W-1:0] PH_PRE  = PH_W'(CLK_DIV / 2 - 1);

  logic [PH_W-1:0] r_ph;
  logic [PH_W-1:0] w_ph_nxt;
  logic            r_sck;

  always_comb begin
    w_ph_nxt = (r_ph == PH_LAST) ? '0 : r_ph + 1'b1;
  end

  // r_sck is computed from the next phase so it always matches the phase of
  // the cycle it is driven in.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ph  <= '0;
      r_sck <= 1'b0;
    end else if (i_en) begin
      r_ph  <= w_ph_nxt;
      r_sck <= (w_ph_nxt >= PH_HALF);
    end else begin
      r_ph  <= '0;
      r_sck <= 1'b0;
    end
  end

  assign o_sck        = r_sck;
  assign o_sck_fall   = i_en & (r_ph == PH_LAST);
  assign o_sck_sample = i_en & (r_ph == PH_PRE);

endmodule

// File: rtl/microroc_sc_loader.sv
// ---------------------------------------------------------------------------
// microroc_sc_loader
// Responder to the sweep controller's LoadSCParameter request. Merges DAC0
// into the base slow-control frame, resets the MICROROC SC register, shifts
// the frame MSB-first on SR_CK/SR_IN and returns a one-cycle
// MicrorocConfigDone pulse.
// Optional feature macro: SC_READBACK_EN
//   defined   : a VERIFY pass reshifts the frame and compares SR_OUT against
//               it; mismatches set the sticky ConfigError.
//   undefined : no verify pass, ConfigError stays 0, SR_OUT is ignored.
// Ports:
//   Clk, reset_n         clock, asynchronous active-low reset
//   LoadSCParameter      load request, rising edge triggers
//   DAC0, BaseConfig     DAC0 value and base frame, latched on accept
//   MicrorocConfigDone   one-cycle completion pulse
//   SCBusy               accepted request through Done pulse
//   SR_RSTB/SR_CK/SR_IN  ASIC slow-control reset, clock, data
//   SR_OUT               ASIC serial readback
//   ConfigError          readback mismatch flag
//
// state     | meaning
// ----------+-------------------------------------------------
// ST_IDLE   | waiting for a load request
// ST_RST    | SR_RSTB held low for RST_CYCLES clk cycles
// ST_SHIFT  | frame shifted out, SC_LEN bit periods
// ST_VERIFY | frame reshifted while SR_OUT is compared
// ST_DONE   | Done pulse, back to idle
// ---------------------------------------------------------------------------
module microroc_sc_loader
  import microroc_sc_pkg::*;
#(
  parameter int SC_LEN     = SC_LEN_DEF,
  parameter int DAC0_POS   = 0,
  parameter int CLK_DIV    = CLK_DIV_DEF,
  parameter int RST_CYCLES = RST_CYCLES_DEF
) (
  input  logic              Clk,
  input  logic              reset_n,
  input  logic              LoadSCParameter,
  input  logic [DAC_W-1:0]  DAC0,
  input  logic [SC_LEN-1:0] BaseConfig,
  output logic              MicrorocConfigDone,
  output logic              SCBusy,
  output logic              SR_RSTB,
  output logic              SR_CK,
  output logic              SR_IN,
  input  logic              SR_OUT,
  output logic              ConfigError
);

  localparam int BIT_W = $clog2(SC_LEN + 1);
  localparam int RC_W  = $clog2(RST_CYCLES + 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(SC_LEN);
  localparam logic [RC_W-1:0]  RC_LOAD  = RC_W'(RST_CYCLES - 1);

  sc_state_e         r_state;
  logic              r_load_q;
  logic              r_load_d;
  logic              r_req;
  logic [SC_LEN-1:0] r_frame;
  logic [SC_LEN-1:0] r_shreg;
  logic [SC_LEN-1:0] w_frame_new;
  logic [BIT_W-1:0]  r_bit;
  logic [BIT_W-1:0]  w_bit_nxt;
  logic [RC_W-1:0]   r_rcnt;
  logic              r_done;
  logic              r_busy;
  logic              r_rstb;
  logic              r_sr_in;
  logic              r_err;
  logic              w_sck_en;
  logic              w_sck_fall;
  logic              w_sck_sample;

  always_comb begin
    w_frame_new                    = BaseConfig;
    w_frame_new[DAC0_POS +: DAC_W] = DAC0;
  end

  assign w_bit_nxt = r_bit + 1'b1;
  assign w_sck_en  = (r_state == ST_SHIFT) || (r_state == ST_VERIFY);

  sc_bit_clock_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_sck (
    .i_clk        (Clk),
    .i_rst_n      (reset_n),
    .i_en         (w_sck_en),
    .o_sck        (SR_CK),
    .o_sck_fall   (w_sck_fall),
    .o_sck_sample (w_sck_sample)
  );

  // Request edge detect is fully registered; r_req is a one-cycle pulse that
  // is simply lost if the FSM is not idle.
  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      r_load_q <= 1'b0;
      r_load_d <= 1'b0;
      r_req    <= 1'b0;
    end else begin
      r_load_q <= LoadSCParameter;
      r_load_d <= r_load_q;
      r_req    <= r_load_q & ~r_load_d;
    end
  end

  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_frame <= '0;
      r_shreg <= '0;
      r_bit   <= '0;
      r_rcnt  <= '0;
      r_done  <= 1'b0;
      r_busy  <= 1'b0;
      r_rstb  <= 1'b1;
      r_sr_in <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (r_req) begin
            r_state <= ST_RST;
            r_frame <= w_frame_new;
            r_busy  <= 1'b1;
            r_rstb  <= 1'b0;
            r_rcnt  <= RC_LOAD;
            r_err   <= 1'b0;
          end
        end
        ST_RST: begin
          if (r_rcnt == '0) begin
            r_state <= ST_SHIFT;
            r_rstb  <= 1'b1;
            r_sr_in <= r_frame[SC_LEN-1];
            r_shreg <= r_frame << 1;
            r_bit   <= '0;
          end else begin
            r_rcnt <= r_rcnt - 1'b1;
          end
        end
        ST_SHIFT, ST_VERIFY: begin
          if (w_sck_fall) begin
            if (w_bit_nxt == BIT_LAST) begin
              r_bit <= '0;
`ifdef SC_READBACK_EN
              if (r_state == ST_SHIFT) begin
                r_state <= ST_VERIFY;
                r_sr_in <= r_frame[SC_LEN-1];
                r_shreg <= r_frame << 1;
              end else begin
                r_state <= ST_DONE;
                r_done  <= 1'b1;
                r_sr_in <= 1'b0;
              end
`else
              r_state <= ST_DONE;
              r_done  <= 1'b1;
              r_sr_in <= 1'b0;
`endif
            end else begin
              r_bit   <= w_bit_nxt;
              r_sr_in <= r_shreg[SC_LEN-1];
              r_shreg <= r_shreg << 1;
            end
          end
`ifdef SC_READBACK_EN
          // SR_IN still holds the bit the ASIC should be presenting back, as
          // the reshift is aligned with the first pass one frame later.
          if ((r_state == ST_VERIFY) && w_sck_sample && (SR_OUT != r_sr_in)) begin
            r_err <= 1'b1;
          end
`endif
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_rstb  <= 1'b1;
        end
      endcase
    end
  end

`ifndef SC_READBACK_EN
  logic w_unused_rb;
  assign w_unused_rb = SR_OUT ^ w_sck_sample;
`endif

  assign MicrorocConfigDone = r_done;
  assign SCBusy             = r_busy;
  assign SR_RSTB            = r_rstb;
  assign SR_IN              = r_sr_in;
  assign ConfigError        = r_err;

endmodule
